// File: rtl/array_t_pkg.sv
// Shared constants and the bit-exact truncated-product function for array_t.
// trunc_model is used by the datapath self-check and by verification benches.
package array_t_pkg;

    localparam int BIT_WIDTH        = 6;
    localparam int RESULT_BIT_WIDTH = 8;
    localparam int TRUNC_COLS       = 3;
    localparam int CORRECTION       = 8;
    localparam int SHIFT            = 2*BIT_WIDTH - RESULT_BIT_WIDTH;

    function automatic logic [RESULT_BIT_WIDTH-1:0] trunc_model(
        input logic [BIT_WIDTH-1:0] x,
        input logic [BIT_WIDTH-1:0] y
    );
        logic [2*BIT_WIDTH-1:0] kept;
        kept = '0;
        for (int i = 0; i < BIT_WIDTH; i++) begin
            for (int j = 0; j < BIT_WIDTH; j++) begin
                if (i + j >= TRUNC_COLS) begin
                    kept = kept + ((2*BIT_WIDTH)'(x[i] & y[j]) << (i + j));
                end
            end
        end
        kept = kept + (2*BIT_WIDTH)'(CORRECTION);
        return RESULT_BIT_WIDTH'(kept >> SHIFT);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// 1-bit full adder, the leaf cell of the carry-save array and final ripple row.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/array_t.sv
// Truncated unsigned array multiplier: upper RESULT_BIT_WIDTH bits of op_x*op_y
// with low partial-product columns dropped and a constant correction. 1-cycle latency.
module array_t #(
    parameter int BIT_WIDTH        = array_t_pkg::BIT_WIDTH,
    parameter int RESULT_BIT_WIDTH = array_t_pkg::RESULT_BIT_WIDTH,
    parameter int TRUNC_COLS       = array_t_pkg::TRUNC_COLS,
    parameter int CORRECTION       = array_t_pkg::CORRECTION
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BIT_WIDTH-1:0]        op_x,
    input  logic [BIT_WIDTH-1:0]        op_y,
    output logic [RESULT_BIT_WIDTH-1:0] result_trunc
);
    import array_t_pkg::*;

    localparam int W2    = 2*BIT_WIDTH;
    localparam int SHIFT = W2 - RESULT_BIT_WIDTH;

    logic [W2-1:0]               s_fin;
    logic [W2-1:0]               c_fin;
    logic [RESULT_BIT_WIDTH-1:0] r_comb;

    // Carry-save array, one row per op_y bit. Row 0 starts with CORRECTION
    // preloaded as carry-ins; truncated columns just pass those bits through.
    for (genvar j = 0; j < BIT_WIDTH; j++) begin : g_row
        logic [W2-1:0] s_in, c_in, s_out, c_out;

        if (j == 0) begin : g_first
            assign s_in = '0;
            assign c_in = W2'(CORRECTION);
        end else begin : g_next
            assign s_in = g_row[j-1].s_out;
            assign c_in = g_row[j-1].c_out;
        end

        for (genvar k = 0; k < W2; k++) begin : g_col
            if (k < TRUNC_COLS) begin : g_skip
                assign s_out[k] = s_in[k];
                assign c_out[k] = c_in[k];
            end else begin : g_cell
                logic pp;
                if (k >= j && k - j < BIT_WIDTH) begin : g_pp
                    assign pp = op_x[k-j] & op_y[j];
                end else begin : g_nopp
                    assign pp = 1'b0;
                end

                if (k == TRUNC_COLS) begin : g_c0
                    assign c_out[k] = 1'b0;
                end

                if (k < W2 - 1) begin : g_fa
                    fa_cell u_fa (
                        .a   (s_in[k]),
                        .b   (c_in[k]),
                        .cin (pp),
                        .s   (s_out[k]),
                        .cout(c_out[k+1])
                    );
                end else begin : g_msb
                    assign s_out[k] = s_in[k] ^ c_in[k] ^ pp;
                end
            end
        end
    end

    assign s_fin = g_row[BIT_WIDTH-1].s_out;
    assign c_fin = g_row[BIT_WIDTH-1].c_out;

    // Final ripple row; columns below SHIFT only need their carries.
    for (genvar k = 0; k < W2; k++) begin : g_fin
        logic a, b, cin;
        assign a = s_fin[k];
        assign b = c_fin[k];

        if (k == 0) begin : g_ci0
            assign cin = 1'b0;
        end else begin : g_ci
            assign cin = g_fin[k-1].g_co.cout;
        end

        if (k < W2 - 1) begin : g_co
            logic cout;
            if (k < SHIFT) begin : g_lo
                assign cout = (a & b) | (cin & (a ^ b));
            end else begin : g_fa
                fa_cell u_fa (
                    .a   (a),
                    .b   (b),
                    .cin (cin),
                    .s   (r_comb[k-SHIFT]),
                    .cout(cout)
                );
            end
        end else begin : g_top
            assign r_comb[k-SHIFT] = a ^ b ^ cin;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_trunc <= '0;
        end else begin
            result_trunc <= r_comb;
        end
    end

    // The reference function is only sized for the default parameter set.
    if (BIT_WIDTH == array_t_pkg::BIT_WIDTH &&
        RESULT_BIT_WIDTH == array_t_pkg::RESULT_BIT_WIDTH &&
        TRUNC_COLS == array_t_pkg::TRUNC_COLS &&
        CORRECTION == array_t_pkg::CORRECTION) begin : g_chk
        always @(posedge clk) begin
            if (reset) begin
                assert (r_comb == trunc_model(op_x, op_y));
            end
        end
    end

endmodule

// File: tb/tb_array_t.sv
// Random and exhaustive vectors for array_t against an arithmetic reference model.
module tb_array_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op_x  = '0;
    logic [5:0] op_y  = '0;
    logic [7:0] result_trunc;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    array_t dut (
        .clk         (clk),
        .reset       (reset),
        .op_x        (op_x),
        .op_y        (op_y),
        .result_trunc(result_trunc)
    );

    // Ideal product minus the dropped low columns, plus correction, shifted.
    function automatic int ref_r(input int x, input int y);
        int p;
        int d;
        p = x * y;
        d = 0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                if (i + j < 3) begin
                    d += (((x >> i) & 1) * ((y >> j) & 1)) << (i + j);
                end
            end
        end
        return ((p - d + 8) >> 4) & 255;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (result_trunc !== 8'd0) begin
                $display("FAIL reset_hold cycle=%0d got=%0d exp=0", c, result_trunc);
            end else begin
                passed++;
            end
            op_x = (c % 2 == 0) ? 6'd63 : 6'd0;
            op_y = (c % 2 == 0) ? 6'd63 : 6'd0;
        end
        op_x = 6'd63;
        op_y = 6'd63;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (result_trunc !== 8'd247) begin
            $display("FAIL reset_release got=%0d exp=247", result_trunc);
        end else begin
            passed++;
        end
    endtask

    task automatic test_directed();
        int tx[5] = '{0, 1, 16, 32, 63};
        int ty[5] = '{0, 1, 1, 32, 63};
        int te[5] = '{0, 0, 1, 64, 247};
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            op_x = 6'(tx[n]);
            op_y = 6'(ty[n]);
            @(negedge clk);
            total++;
            if (result_trunc !== 8'(te[n])) begin
                $display("FAIL directed x=%0d y=%0d got=%0d exp=%0d",
                         tx[n], ty[n], result_trunc, te[n]);
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_exhaustive();
        int  px = 0;
        int  py = 0;
        bit  have = 1'b0;
        for (int v = 0; v <= 4096; v++) begin
            @(negedge clk);
            if (have) begin
                int diff;
                $display("vec x=%0d y=%0d xy=%0d r=%0d", px, py, px*py, result_trunc);
                total++;
                if (result_trunc !== 8'(ref_r(px, py))) begin
                    $display("FAIL exhaustive x=%0d y=%0d got=%0d exp=%0d",
                             px, py, result_trunc, ref_r(px, py));
                end else begin
                    passed++;
                end
                diff = int'(result_trunc) - ((px * py) >> 4);
                total++;
                if (diff < -1 || diff > 1) begin
                    $display("FAIL error_bound x=%0d y=%0d got=%0d ideal=%0d",
                             px, py, result_trunc, (px * py) >> 4);
                end else begin
                    passed++;
                end
            end
            if (v < 4096) begin
                px   = v / 64;
                py   = v % 64;
                op_x = 6'(px);
                op_y = 6'(py);
                have = 1'b1;
            end
        end
    endtask

    task automatic test_back_to_back_random();
        int  px = 0;
        int  py = 0;
        bit  have = 1'b0;
        for (int v = 0; v <= 400; v++) begin
            @(negedge clk);
            if (have) begin
                total++;
                if (result_trunc !== 8'(ref_r(px, py))) begin
                    $display("FAIL random x=%0d y=%0d got=%0d exp=%0d",
                             px, py, result_trunc, ref_r(px, py));
                end else begin
                    passed++;
                end
            end
            if (v < 400) begin
                px   = int'($urandom_range(63, 0));
                py   = int'($urandom_range(63, 0));
                op_x = 6'(px);
                op_y = 6'(py);
                have = 1'b1;
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int n = 0; n < 4; n++) begin
            int x;
            int y;
            x = int'($urandom_range(63, 16));
            y = int'($urandom_range(63, 16));
            @(negedge clk);
            op_x = 6'(x);
            op_y = 6'(y);
            @(posedge clk);
            #1;
            total++;
            if (result_trunc !== 8'(ref_r(x, y))) begin
                $display("FAIL midreset_before x=%0d y=%0d got=%0d exp=%0d",
                         x, y, result_trunc, ref_r(x, y));
            end else begin
                passed++;
            end
            #1 reset = 1'b0;
            #1;
            total++;
            if (result_trunc !== 8'd0) begin
                $display("FAIL midreset_async got=%0d exp=0", result_trunc);
            end else begin
                passed++;
            end
            #1 reset = 1'b1;
            @(negedge clk);
            total++;
            if (result_trunc !== 8'd0) begin
                $display("FAIL midreset_hold got=%0d exp=0", result_trunc);
            end else begin
                passed++;
            end
            @(negedge clk);
            total++;
            if (result_trunc !== 8'(ref_r(x, y))) begin
                $display("FAIL midreset_resume x=%0d y=%0d got=%0d exp=%0d",
                         x, y, result_trunc, ref_r(x, y));
            end else begin
                passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_exhaustive();
        test_back_to_back_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
